tx_scrambler_gen3: RTL and testbench

// Per-lane Gen3/4/5 (128b/130b) transmit scrambler. Sits in the TX MAC after block framing and before the
// 130b serialiser; mirror of the RX de-scrambler. Scrambles Data Block symbols with the 23-bit LFSR
// G(X)=X23+X21+X16+X8+X5+X2+1, passes Ordered Set symbols and sync headers clear, tracks block position
// (16 symbols/block), and handles SKP hold and EIEOS-triggered LFSR re-seed. One symbol per clock.

---
 rtl/tx_scrambler_gen3.sv | 139 +++++++++++++
 tb/tb_tx_scrambler_gen3.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_scrambler_gen3.sv
// rtl/tx_scrambler_gen3.sv - per-lane 128b/130b transmit scrambler with block framing tracking
// Data symbols are XORed with a G(X)=X23+X21+X16+X8+X5+X2+1 keystream; ordered sets pass in clear.
module tx_scrambler_gen3 #(
    parameter int         SEED_WIDTH = 24,
    parameter int         DATA_WIDTH = 8,
    parameter logic [7:0] SKP_SYM    = 8'hAA
) (
    input  logic                  TX_CLK,
    input  logic                  rst,
    input  logic [SEED_WIDTH-1:0] seed,
    input  logic                  LFSR_RST,
    input  logic                  back_pressure,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sob,
    input  logic [1:0]            in_sync_hdr,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sob,
    output logic [1:0]            out_sync_hdr,
    output logic                  proto_err
);

    typedef enum logic [1:0] {IDLE, DATA_BLK, OS_BLK} state_t;

    // Galois feedback taps below X23; bit 0 receives the feedback via the rotate
    localparam logic [22:0] LFSR_TAPS = 23'h210124;

    function automatic logic [22:0] lfsr_step8(input logic [22:0] q);
        logic [22:0] s;
        s = q;
        for (int i = 0; i < 8; i++) begin
            s = {s[21:0], s[22]} ^ (LFSR_TAPS & {23{s[22]}});
        end
        return s;
    endfunction

    state_t      state;
    logic [3:0]  sym_cnt;
    logic [22:0] lfsr_q;
    logic        eie_s0_zero;
    logic        eie_flag;

    logic [7:0]  key;
    logic [22:0] lfsr_adv;
    logic        hdr_ok;
    logic        hdr_data;
    logic        in_blk;
    logic        blk_end;
    logic        is_skp;
    logic        unused_seed_hi;

    assign key[0] = lfsr_q[22];
    assign key[1] = lfsr_q[21];
    assign key[2] = lfsr_q[20] ^ lfsr_q[22];
    assign key[3] = lfsr_q[19] ^ lfsr_q[21];
    assign key[4] = lfsr_q[18] ^ lfsr_q[20] ^ lfsr_q[22];
    assign key[5] = lfsr_q[17] ^ lfsr_q[19] ^ lfsr_q[21];
    assign key[6] = lfsr_q[16] ^ lfsr_q[18] ^ lfsr_q[20] ^ lfsr_q[22];
    assign key[7] = lfsr_q[15] ^ lfsr_q[17] ^ lfsr_q[19] ^ lfsr_q[21] ^ lfsr_q[22];

    assign lfsr_adv       = lfsr_step8(lfsr_q);
    assign hdr_data       = (in_sync_hdr == 2'b10);
    assign hdr_ok         = hdr_data || (in_sync_hdr == 2'b01);
    assign in_blk         = (state != IDLE);
    assign blk_end        = (sym_cnt == 4'd15);
    assign is_skp         = (in_data == SKP_SYM);
    assign unused_seed_hi = ^seed[SEED_WIDTH-1:23];

    always_ff @(posedge TX_CLK or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            sym_cnt      <= 4'd0;
            lfsr_q       <= seed[22:0];
            eie_s0_zero  <= 1'b0;
            eie_flag     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_sob      <= 1'b0;
            out_sync_hdr <= 2'b00;
            proto_err    <= 1'b0;
        end else begin
            if (!back_pressure) begin
                out_valid <= 1'b0;
                proto_err <= 1'b0;
                if (in_valid) begin
                    out_valid    <= 1'b1;
                    out_data     <= in_data;
                    out_sob      <= in_sob;
                    out_sync_hdr <= in_sync_hdr;
                    if (in_sob) begin
                        sym_cnt     <= 4'd0;
                        eie_flag    <= 1'b0;
                        eie_s0_zero <= (in_data == '0);
                        if (!hdr_ok) begin
                            proto_err <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= hdr_data ? DATA_BLK : OS_BLK;
                            // Premature sob restarts the block but leaves the keystream untouched
                            if (in_blk && !blk_end) begin
                                proto_err <= 1'b1;
                            end else if (hdr_data) begin
                                out_data <= in_data ^ key;
                                lfsr_q   <= lfsr_adv;
                            end else if (!is_skp) begin
                                lfsr_q <= lfsr_adv;
                            end
                        end
                    end else if (!in_blk || blk_end) begin
                        out_valid <= 1'b0;
                        proto_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        sym_cnt <= sym_cnt + 4'd1;
                        if (state == DATA_BLK) begin
                            out_data <= in_data ^ key;
                            lfsr_q   <= lfsr_adv;
                        end else begin
                            if (sym_cnt == 4'd0 && eie_s0_zero && in_data == '1) begin
                                eie_flag <= 1'b1;
                            end
                            // Last symbol of an EIEOS re-seeds instead of advancing
                            if (sym_cnt == 4'd14 && eie_flag) begin
                                lfsr_q <= seed[22:0];
                            end else if (!is_skp) begin
                                lfsr_q <= lfsr_adv;
                            end
                        end
                    end
                end
            end
            if (LFSR_RST) begin
                lfsr_q <= seed[22:0];
            end
        end
    end

endmodule

// File: tb/tb_tx_scrambler_gen3.sv
// tb/tb_tx_scrambler_gen3.sv - scoreboard bench for tx_scrambler_gen3 against a keystream-position model
module tb_tx_scrambler_gen3;

    localparam logic [23:0] SEED = 24'h1DBFBC;
    localparam logic [7:0]  SKP  = 8'hAA;

    logic        TX_CLK = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] seed = SEED;
    logic        LFSR_RST = 1'b0;
    logic        back_pressure = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_sob = 1'b0;
    logic [1:0]  in_sync_hdr = 2'b00;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sob;
    logic [1:0]  out_sync_hdr;
    logic        proto_err;

    always #5 TX_CLK = ~TX_CLK;

    tx_scrambler_gen3 dut (
        .TX_CLK        (TX_CLK),
        .rst           (rst),
        .seed          (seed),
        .LFSR_RST      (LFSR_RST),
        .back_pressure (back_pressure),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_sob        (in_sob),
        .in_sync_hdr   (in_sync_hdr),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_sob       (out_sob),
        .out_sync_hdr  (out_sync_hdr),
        .proto_err     (proto_err)
    );

    typedef struct {
        logic       v;
        logic       err;
        logic [7:0] d;
        logic       sob;
        logic [1:0] hdr;
        logic [7:0] orig;
        logic [7:0] key;
        int         due;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        bp_at_edge = 1'b0;
    logic [12:0] snap = '0;

    // Keystream as a byte sequence indexed by advances since the last seed load
    logic [7:0]  ks_q[$];
    logic [22:0] gen_q = SEED[22:0];
    int          pos = 0;
    int          m_state = 0;
    int          m_idx = 0;
    bit          m_s0z = 0;
    bit          m_eie = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] ks(input int p);
        logic [7:0] b;
        while (ks_q.size() <= p) begin
            for (int i = 0; i < 8; i++) begin
                b[i] = gen_q[22];
                gen_q = gen_q[22] ? ((gen_q << 1) ^ 23'h210125) : (gen_q << 1);
            end
            ks_q.push_back(b);
        end
        return ks_q[p];
    endfunction

    task automatic model_accept(input logic [7:0] d, input logic sob, input logic [1:0] hdr, input logic lrst);
        exp_t e;
        bit   restart;
        e.v = 1'b1; e.err = 1'b0; e.sob = sob; e.hdr = hdr; e.orig = d; e.key = 8'h00; e.due = cyc + 1;
        if (sob) begin
            restart = (m_state != 0) && (m_idx != 15);
            m_idx = 0; m_eie = 0; m_s0z = (d == 8'h00);
            if (hdr != 2'b10 && hdr != 2'b01) begin
                e.err = 1'b1; m_state = 0;
            end else begin
                m_state = (hdr == 2'b10) ? 1 : 2;
                if (restart) e.err = 1'b1;
                else if (m_state == 1) begin e.key = ks(pos); pos++; end
                else if (d != SKP) pos++;
            end
        end else if (m_state == 0 || m_idx == 15) begin
            e.v = 1'b0; e.err = 1'b1; m_state = 0;
        end else begin
            m_idx++;
            if (m_state == 1) begin
                e.key = ks(pos); pos++;
            end else begin
                if (m_idx == 1 && m_s0z && d == 8'hFF) m_eie = 1;
                if (m_idx == 15 && m_eie) pos = 0;
                else if (d != SKP) pos++;
            end
        end
        e.d = d ^ e.key;
        if (lrst) pos = 0;
        sbq.push_back(e);
    endtask

    task automatic send(input logic [7:0] d, input logic sob, input logic [1:0] hdr, input logic lrst);
        in_valid = 1'b1; in_data = d; in_sob = sob; in_sync_hdr = hdr;
        back_pressure = 1'b0; LFSR_RST = lrst;
        model_accept(d, sob, hdr, lrst);
        @(posedge TX_CLK); #2;
        in_valid = 1'b0; LFSR_RST = 1'b0;
    endtask

    task automatic idle(input int n, input logic lrst);
        in_valid = 1'b0; LFSR_RST = lrst;
        if (lrst) pos = 0;
        repeat (n) begin @(posedge TX_CLK); #2; LFSR_RST = 1'b0; end
    endtask

    task automatic stall(input int n);
        back_pressure = 1'b1; in_valid = 1'b1; in_data = 8'($urandom); in_sob = 1'b1; in_sync_hdr = 2'b11;
        repeat (n) begin @(posedge TX_CLK); #2; end
        back_pressure = 1'b0; in_valid = 1'b0;
    endtask

    task automatic send_blk(input logic [1:0] hdr, input logic [7:0] b [16]);
        for (int i = 0; i < 16; i++) send(b[i], i == 0, hdr, 1'b0);
    endtask

    task automatic rand_block();
        logic [7:0] b [16];
        logic [1:0] hdr;
        int         kind;
        kind = $urandom_range(0, 99);
        hdr = (kind < 65) ? 2'b10 : 2'b01;
        for (int i = 0; i < 16; i++) begin
            if (kind < 65) b[i] = 8'($urandom);
            else if (kind >= 92) b[i] = i[0] ? 8'hFF : 8'h00;
            else b[i] = ($urandom_range(0, 3) == 0) ? SKP : 8'($urandom);
        end
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 7) == 0) idle(1, 1'b0);
            if ($urandom_range(0, 9) == 0) stall($urandom_range(1, 3));
            send(b[i], i == 0, hdr, $urandom_range(0, 199) == 0);
        end
    endtask

    always @(posedge TX_CLK) begin
        bp_at_edge <= back_pressure;
        cyc <= cyc + 1;
    end

    always @(negedge TX_CLK) begin
        if (!rst) begin
            chk("reset_out_valid", 32'(out_valid), 32'd0);
            chk("reset_proto_err", 32'(proto_err), 32'd0);
        end else if (bp_at_edge) begin
            chk("bp_freeze", 32'({out_valid, out_data, out_sob, out_sync_hdr, proto_err}), 32'(snap));
        end else if (out_valid || proto_err) begin
            if (sbq.size() == 0) begin
                chk("unexpected_output", 32'({out_valid, proto_err}), 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("latency", 32'(cyc), 32'(mon_e.due));
                chk("out_valid", 32'(out_valid), 32'(mon_e.v));
                chk("proto_err", 32'(proto_err), 32'(mon_e.err));
                if (mon_e.v) begin
                    chk("out_data", 32'(out_data), 32'(mon_e.d));
                    chk("out_sob", 32'(out_sob), 32'(mon_e.sob));
                    chk("out_sync_hdr", 32'(out_sync_hdr), 32'(mon_e.hdr));
                    chk("loopback", 32'(out_data ^ mon_e.key), 32'(mon_e.orig));
                end
            end
        end
        snap = {out_valid, out_data, out_sob, out_sync_hdr, proto_err};
    end

    initial begin
        logic [7:0] b [16];
        repeat (3) @(posedge TX_CLK);
        #2;
        chk("reset_data", 32'(out_data), 32'd0);
        chk("reset_sob", 32'(out_sob), 32'd0);
        chk("reset_hdr", 32'(out_sync_hdr), 32'd0);
        rst = 1'b1;
        idle(2, 1'b0);

        // Golden keystream from seed on an all-zero data block
        for (int i = 0; i < 16; i++) b[i] = 8'h00;
        send_blk(2'b10, b);

        // Data, OS with SKP hold, data
        for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
        send_blk(2'b10, b);
        for (int i = 0; i < 16; i++) b[i] = (i == 0) ? 8'hE1 : (i < 4) ? SKP : 8'h00;
        send_blk(2'b01, b);
        for (int i = 0; i < 16; i++) b[i] = 8'h00;
        send_blk(2'b10, b);

        // EIEOS re-seed, then zero data block
        for (int i = 0; i < 16; i++) b[i] = i[0] ? 8'hFF : 8'h00;
        send_blk(2'b01, b);
        for (int i = 0; i < 16; i++) b[i] = 8'h00;
        send_blk(2'b10, b);

        // Five-cycle stall in the middle of a data block
        for (int i = 0; i < 16; i++) begin
            if (i == 8) stall(5);
            send(8'($urandom), i == 0, 2'b10, 1'b0);
        end

        // Framing violations: early sob, bad header, missing sob
        for (int i = 0; i < 8; i++) send(8'($urandom), i == 0, 2'b10, 1'b0);
        for (int i = 0; i < 16; i++) send(8'($urandom), i == 0, 2'b10, 1'b0);
        send(8'h3C, 1'b0, 2'b10, 1'b0);
        idle(1, 1'b0);
        send(8'h5A, 1'b1, 2'b11, 1'b0);
        idle(1, 1'b0);
        send(8'h77, 1'b0, 2'b10, 1'b0);
        for (int i = 0; i < 16; i++) b[i] = 8'h00;
        send_blk(2'b10, b);

        // Asynchronous reset at symbol 9, then LFSR_RST
        for (int i = 0; i < 9; i++) send(8'($urandom), i == 0, 2'b10, 1'b0);
        idle(1, 1'b0);
        rst = 1'b0; in_valid = 1'b1; in_data = 8'h99; in_sob = 1'b0; in_sync_hdr = 2'b10;
        repeat (3) begin @(posedge TX_CLK); #2; end
        rst = 1'b1; in_valid = 1'b0;
        m_state = 0; m_idx = 0; m_eie = 0; m_s0z = 0; pos = 0;
        send(8'h55, 1'b0, 2'b10, 1'b0);
        idle(1, 1'b1);
        send_blk(2'b10, b);

        for (int n = 0; n < 1000; n++) rand_block();

        idle(4, 1'b0);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
